uart_rx: RTL

UART receiver; the receive-side counterpart of `uart_tx`, fed by the 8x-oversampled `baud_generator` tick (`BAUD_DIV` 651 at 50 MHz gives 9600 baud x 8). It recovers 8N1 frames, LSB first, idle-high, from an asynchronous serial pin. It presents each byte on a valid/ready holding register and flags framing errors and overruns. It sits in `tt_um_javibajocero_top` beside `uart_tx`, with `rx_serial` driven from a dedicated input.

---
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Valid/ready holding-register handshake between the UART receiver and its consumer.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver on an 8x oversampled baud tick: majority vote of samples 3..5,
// valid/ready holding register, framing-error and overrun pulses.
module uart_rx #(
    parameter int OVERSAMPLE = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      baud_tick,
    input  logic      rx_serial,
    uart_rx_if.master rx,
    output logic      frame_error,
    output logic      overrun,
    output logic      busy
);

    localparam logic [2:0] LAST_SAMPLE = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] STOP_EVAL   = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_scnt;
    logic [2:0] w_scnt_nxt;
    logic [2:0] r_bidx;
    logic [2:0] w_bidx_nxt;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_s3;
    logic       r_s4;
    logic       r_s5;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_ferr;
    logic       r_ovr;
    logic       w_rxs;
    logic       w_maj;
    logic       w_sampling;
    logic       w_shift_en;
    logic       w_stop_ok;
    logic       w_stop_bad;
    logic       w_load;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // STOP is judged on the scnt=5 tick itself, so the third sample is taken live.
    assign w_maj      = majority3(r_s3, r_s4, (r_scnt == STOP_EVAL) ? w_rxs : r_s5);
    assign w_sampling = baud_tick && (r_state inside {START, DATA, STOP});

    always_ff @(posedge clk) begin
        if (w_sampling) begin
            case (r_scnt)
                3'd3:    r_s3 <= w_rxs;
                3'd4:    r_s4 <= w_rxs;
                3'd5:    r_s5 <= w_rxs;
                default: ;
            endcase
        end
        if (w_shift_en) begin
            r_shift <= {w_maj, r_shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_scnt  <= 3'd0;
            r_bidx  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_bidx  <= w_bidx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_bidx_nxt  = r_bidx;
        w_shift_en  = 1'b0;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        if (baud_tick) begin
            case (r_state)
                IDLE: begin
                    w_scnt_nxt = 3'd0;
                    if (!w_rxs) begin
                        w_state_nxt = START;
                    end
                end
                START: begin
                    w_scnt_nxt = r_scnt + 3'd1;
                    if (r_scnt == LAST_SAMPLE) begin
                        w_scnt_nxt  = 3'd0;
                        w_bidx_nxt  = 3'd0;
                        w_state_nxt = w_maj ? IDLE : DATA;
                    end
                end
                DATA: begin
                    w_scnt_nxt = r_scnt + 3'd1;
                    if (r_scnt == LAST_SAMPLE) begin
                        w_scnt_nxt = 3'd0;
                        w_shift_en = 1'b1;
                        if (r_bidx == 3'd7) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bidx_nxt = r_bidx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    w_scnt_nxt = r_scnt + 3'd1;
                    if (r_scnt == STOP_EVAL) begin
                        w_scnt_nxt  = 3'd0;
                        w_stop_ok   = w_maj;
                        w_stop_bad  = !w_maj;
                        w_state_nxt = w_maj ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    w_scnt_nxt = 3'd0;
                    if (w_rxs) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_scnt_nxt  = 3'd0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // A consumer taking the old byte in the delivery cycle frees the register for the new one.
    assign w_load = w_stop_ok && (!r_valid || rx.rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_stop_bad;
            r_ovr  <= w_stop_ok && r_valid && !rx.rx_ready;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx.rx_data  = r_data;
    assign rx.rx_valid = r_valid;
    assign frame_error = r_ferr;
    assign overrun     = r_ovr;
    assign busy        = (r_state != IDLE);

endmodule
